// File: rtl/xor_memory_pkg.sv
// ----------------------------------------------------------------------------
// xor_memory_pkg : shared types and default sizing for xor_memory_scheduler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package xor_memory_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_PORTS = 2;
  localparam int DEF_REQS  = 4;

  localparam int ADDR_W = $clog2(DEF_DEPTH);
  localparam int REQ_W  = (DEF_REQS > 1) ? $clog2(DEF_REQS) : 1;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
  } hazard_t;

  typedef struct packed {
    logic             valid;
    logic [REQ_W-1:0] req;
  } rsp_map_t;

  // Round-robin successor with wrap at reqs-1.
  function automatic logic [REQ_W-1:0] rr_next(input logic [REQ_W-1:0] idx, input int reqs);
    if (int'(idx) == reqs - 1) return '0;
    return idx + REQ_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_port_allocator.sv
// ----------------------------------------------------------------------------
// rr_port_allocator : combinational rotating scan granting requests to ports
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_port_allocator
  import xor_memory_pkg::*;
#(
  parameter int REQS  = DEF_REQS,
  parameter int PORTS = DEF_PORTS
) (
  input  logic [REQS-1:0]   valid,
  input  logic [REQS-1:0]   we,
  input  logic [ADDR_W-1:0] addr [REQS],
  input  logic [REQ_W-1:0]  rr_ptr,
  input  hazard_t           hazard [PORTS],
  output logic [REQS-1:0]   grant,
  output logic [PORTS-1:0]  port_used,
  output logic [REQ_W-1:0]  port_req [PORTS],
  output logic              any_grant,
  output logic [REQ_W-1:0]  last_idx
);

  logic [REQ_W-1:0] scan [REQS];
  logic [REQS-1:0]  wr_cand;
  logic             elig;
  logic             placed;

  for (genvar i = 0; i < REQS; i++) begin : g_scan
    logic [REQ_W:0] sum;
    logic [REQ_W:0] wrapped;
    assign sum     = {1'b0, rr_ptr} + (REQ_W+1)'(i);
    assign wrapped = sum - (REQ_W+1)'(REQS);
    assign scan[i] = (sum >= (REQ_W+1)'(REQS)) ? wrapped[REQ_W-1:0] : sum[REQ_W-1:0];
  end

  // Writes that survive the write/write collision rule, indexed by scan position.
  // Reads are checked against every such write so a read never races a
  // same-cycle write to its address, whichever order they appear in.
  always_comb begin
    wr_cand = '0;
    for (int i = 0; i < REQS; i++) begin
      wr_cand[i] = valid[scan[i]] & we[scan[i]];
      for (int j = 0; j < i; j++) begin
        if (valid[scan[j]] && we[scan[j]] && (addr[scan[j]] == addr[scan[i]]))
          wr_cand[i] = 1'b0;
      end
    end
  end

  always_comb begin
    grant     = '0;
    port_used = '0;
    any_grant = 1'b0;
    last_idx  = rr_ptr;
    elig      = 1'b0;
    placed    = 1'b0;
    for (int k = 0; k < PORTS; k++) port_req[k] = '0;

    for (int i = 0; i < REQS; i++) begin
      elig = 1'b0;
      if (valid[scan[i]]) begin
        if (we[scan[i]]) begin
          elig = wr_cand[i];
        end else begin
          elig = 1'b1;
          for (int k = 0; k < PORTS; k++)
            if (hazard[k].valid && (hazard[k].addr == addr[scan[i]])) elig = 1'b0;
          for (int j = 0; j < REQS; j++)
            if (wr_cand[j] && (addr[scan[j]] == addr[scan[i]])) elig = 1'b0;
        end
      end
      placed = 1'b0;
      for (int k = 0; k < PORTS; k++) begin
        if (elig && !placed && !port_used[k]) begin
          port_used[k]     = 1'b1;
          port_req[k]      = scan[i];
          grant[scan[i]]   = 1'b1;
          any_grant        = 1'b1;
          last_idx         = scan[i];
          placed           = 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xor_memory_scheduler.sv
// ----------------------------------------------------------------------------
// xor_memory_scheduler : shares one multi-port xor_memory among REQS requesters
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module xor_memory_scheduler
  import xor_memory_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PORTS = DEF_PORTS,
  parameter int REQS  = DEF_REQS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQS-1:0]          req_valid,
  input  logic [REQS-1:0]          req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr [REQS],
  input  logic [WIDTH-1:0]         req_wdata [REQS],
  output logic [REQS-1:0]          req_ready,
  output logic [REQS-1:0]          rsp_valid,
  output logic [WIDTH-1:0]         rsp_data [REQS],
  output logic [$clog2(DEPTH)-1:0] mem_addr [PORTS],
  output logic [WIDTH-1:0]         mem_d [PORTS],
  output logic [PORTS-1:0]         mem_en,
  input  logic [WIDTH-1:0]         mem_q [PORTS]
);

  logic [REQ_W-1:0] rr_ptr;
  hazard_t          hazard  [PORTS];
  rsp_map_t         rsp_map [PORTS];

  logic [REQS-1:0]  grant;
  logic [PORTS-1:0] port_used;
  logic [PORTS-1:0] port_live;
  logic [PORTS-1:0] port_wr;
  logic [REQ_W-1:0] port_req [PORTS];
  logic             any_grant;
  logic [REQ_W-1:0] last_idx;

  rr_port_allocator #(
    .REQS  (REQS),
    .PORTS (PORTS)
  ) u_alloc (
    .valid     (req_valid),
    .we        (req_we),
    .addr      (req_addr),
    .rr_ptr    (rr_ptr),
    .hazard    (hazard),
    .grant     (grant),
    .port_used (port_used),
    .port_req  (port_req),
    .any_grant (any_grant),
    .last_idx  (last_idx)
  );

  // Nothing is granted or driven to memory while reset is held.
  assign req_ready = grant & {REQS{rst_n}};
  assign port_live = port_used & {PORTS{rst_n}};

  for (genvar k = 0; k < PORTS; k++) begin : g_port
    assign port_wr[k]  = port_live[k] & req_we[port_req[k]];
    assign mem_en[k]   = port_wr[k];
    assign mem_addr[k] = port_live[k] ? req_addr[port_req[k]] : '0;
    assign mem_d[k]    = port_wr[k] ? req_wdata[port_req[k]] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int k = 0; k < PORTS; k++) begin
        hazard[k]  <= '0;
        rsp_map[k] <= '0;
      end
    end else begin
      if (any_grant) rr_ptr <= rr_next(last_idx, REQS);
      for (int k = 0; k < PORTS; k++) begin
        hazard[k]  <= '{valid: port_wr[k], addr: req_addr[port_req[k]]};
        rsp_map[k] <= '{valid: port_live[k] & ~port_wr[k], req: port_req[k]};
      end
    end
  end

  // Memory read data arrives one cycle after issue; steer it by last cycle's map.
  always_comb begin
    rsp_valid = '0;
    for (int r = 0; r < REQS; r++) rsp_data[r] = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (rsp_map[k].valid) begin
        rsp_valid[rsp_map[k].req] = 1'b1;
        rsp_data[rsp_map[k].req]  = mem_q[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xor_memory_scheduler.sv
// ----------------------------------------------------------------------------
// tb_xor_memory_scheduler : scoreboard bench with a behavioural xor_memory model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_xor_memory_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_valid, req_we, req_ready, rsp_valid;
  logic [7:0] req_addr [4];
  logic [7:0] req_wdata [4];
  logic [7:0] rsp_data [4];
  logic [7:0] mem_addr [2];
  logic [7:0] mem_d [2];
  logic [1:0] mem_en;
  logic [7:0] mem_q [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xor_memory_scheduler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .mem_addr  (mem_addr),
    .mem_d     (mem_d),
    .mem_en    (mem_en),
    .mem_q     (mem_q)
  );

  function automatic logic [7:0] init_val(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  // Memory model: registered read, writes land one edge after capture.
  logic [7:0] mem [256];
  logic       loaded = 1'b0;
  logic [1:0] pend_en = '0;
  logic [7:0] pend_a [2];
  logic [7:0] pend_d [2];

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      loaded <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++) if (pend_en[k]) mem[pend_a[k]] <= pend_d[k];
    end
    for (int k = 0; k < 2; k++) begin
      mem_q[k]   <= mem[mem_addr[k]];
      pend_en[k] <= mem_en[k];
      pend_a[k]  <= mem_addr[k];
      pend_d[k]  <= mem_d[k];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int         r;
    logic [7:0] d;
    int         due;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] ref_mem [256];
  logic       ref_loaded = 1'b0;
  logic [3:0] last_grant = '0;

  // Monitor: compare responses due this cycle, then record this cycle's grants.
  always @(negedge clk) begin
    logic [3:0] ev;
    logic [7:0] ed [4];
    exp_t       e;
    if (!ref_loaded) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      ref_loaded = 1'b1;
    end
    if (!rst_n) sb.delete();
    ev = '0;
    for (int r = 0; r < 4; r++) ed[r] = '0;
    while (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      ev[e.r] = 1'b1;
      ed[e.r] = e.d;
    end
    check("rsp_valid", rsp_valid, ev);
    for (int r = 0; r < 4; r++) if (ev[r]) check("rsp_data", rsp_data[r], ed[r]);
    for (int r = 0; r < 4; r++) begin
      last_grant[r] = req_valid[r] & req_ready[r];
      if (last_grant[r]) begin
        if (req_we[r]) ref_mem[req_addr[r]] = req_wdata[r];
        else sb.push_back('{r: r, d: ref_mem[req_addr[r]], due: cyc + 1});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) if (last_grant[r]) req_valid[r] = 1'b0;
  endtask

  task automatic set_rd(input int r, input int a);
    req_valid[r] = 1'b1;
    req_we[r]    = 1'b0;
    req_addr[r]  = 8'(a);
    req_wdata[r] = 8'h00;
  endtask

  task automatic set_wr(input int r, input int a, input logic [7:0] d);
    req_valid[r] = 1'b1;
    req_we[r]    = 1'b1;
    req_addr[r]  = 8'(a);
    req_wdata[r] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_rdy;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    for (int r = 0; r < 4; r++) begin
      req_addr[r]  = '0;
      req_wdata[r] = '0;
    end

    // Reset holds grants and memory enables off even with requests present.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'hF;
    req_we    = 4'b0101;
    @(negedge clk);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_mem_en", mem_en, 2'b00);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    @(negedge clk);
    check("idle_mem_en", mem_en, 2'b00);
    check("idle_rsp_valid", rsp_valid, 4'b0000);
    check("idle_rr_ptr", dut.rr_ptr, 0);
    tick();

    // Four reads, two ports: two grants per cycle, rr_ptr wraps to 0.
    for (int r = 0; r < 4; r++) set_rd(r, 10 + r);
    @(negedge clk);
    check("rd_cycle1", req_ready, 4'b0011);
    tick();
    @(negedge clk);
    check("rd_cycle2", req_ready, 4'b1100);
    tick();
    check("rr_wrap", dut.rr_ptr, 0);
    tick();

    // Same-address writes: lower scan position first, the other next cycle.
    set_wr(0, 3, 8'h11);
    set_wr(2, 3, 8'h22);
    @(negedge clk);
    check("ww_first", req_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("ww_second", req_ready, 4'b0100);
    tick();
    set_rd(3, 3);
    @(negedge clk);
    check("ww_rd_hazard", req_ready, 4'b0000);
    tick();
    @(negedge clk);
    check("ww_rd_grant", req_ready, 4'b1000);
    tick();
    tick();

    // Write then read of the same address: read stalls two cycles.
    set_wr(0, 7, 8'hA5);
    set_rd(1, 7);
    @(negedge clk);
    check("wr_ready", req_ready, 4'b0001);
    check("wr_mem_en", mem_en, 2'b01);
    check("wr_mem_addr", mem_addr[0], 8'd7);
    check("wr_mem_d", mem_d[0], 8'hA5);
    check("unused_addr", mem_addr[1], 8'd0);
    check("unused_d", mem_d[1], 8'd0);
    tick();
    @(negedge clk);
    check("rd_stale_t1", req_ready, 4'b0000);
    tick();
    @(negedge clk);
    check("rd_after_wr", req_ready, 4'b0010);
    check("rd_mem_en", mem_en, 2'b00);
    check("rd_mem_addr", mem_addr[0], 8'd7);
    tick();
    @(negedge clk);
    check("rd_after_wr_valid", rsp_valid[1], 1'b1);
    check("rd_after_wr_data", rsp_data[1], 8'hA5);
    tick();

    // Lone requester is served every cycle.
    for (int i = 0; i < 8; i++) begin
      set_rd(1, 20 + i);
      @(negedge clk);
      check("solo_grant", req_ready, 4'b0010);
      tick();
    end

    // All four contend: rotation alternates pairs starting after requester 1.
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 4; r++) if (!req_valid[r]) set_rd(r, 30 + r + 4 * i);
      exp_rdy = (i % 2 == 0) ? 4'b1100 : 4'b0011;
      @(negedge clk);
      check("rotate_grant", req_ready, exp_rdy);
      tick();
    end
    req_valid = '0;
    tick();
    tick();

    // Reset one cycle after a read grant drops its response.
    set_rd(0, 40);
    set_wr(1, 41, 8'h77);
    @(negedge clk);
    check("pre_rst_grant", req_ready, 4'b0011);
    tick();
    rst_n = 1'b0;
    set_rd(2, 50);
    @(negedge clk);
    check("mid_rst_ready", req_ready, 4'b0000);
    check("mid_rst_mem_en", mem_en, 2'b00);
    tick();
    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rsp_data", rsp_data[0], 8'h00);
      tick();
    end
    check("post_rst_rr_ptr", dut.rr_ptr, 0);
    check("post_rst_hz0", dut.hazard[0].valid, 1'b0);
    check("post_rst_hz1", dut.hazard[1].valid, 1'b0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
